// File: rtl/dequeue_sched_pkg.sv
// Shared definitions for the per-port dequeue scheduler: FSM encoding and default widths.
package dequeue_sched_pkg;

  localparam int DEQ_NUM_QUEUES      = 8;
  localparam int DEQ_SEL_WIDTH       = 3;
  localparam int DEQ_WEIGHT_WIDTH    = 4;
  localparam int DEQ_LEN_WIDTH       = 7;
  localparam int DEQ_STATS_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RELOAD = 2'd1,
    ST_GRANT  = 2'd2,
    ST_XFER   = 2'd3
  } deq_state_e;

endpackage

// File: rtl/dequeue_scheduler_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start_i, with wrap.
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] start_i,
  output logic          found_o,
  output logic [SW-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = SW'(j);
      end
    end
  end

endmodule

// File: rtl/dequeue_scheduler.sv
// Dequeue scheduler for one output port, strict priority or WRR; optional DEQ_SCHED_STATS_EN grant counters.
// States: IDLE wait/pick | RELOAD refill credits | GRANT one-cycle pulse | XFER wait for rd_eop
module dequeue_scheduler
  import dequeue_sched_pkg::*;
#(
  parameter int num_of_queues     = DEQ_NUM_QUEUES,
  parameter int queue_sel_width   = DEQ_SEL_WIDTH,
  parameter int weight_width      = DEQ_WEIGHT_WIDTH,
  parameter int pack_length_width = DEQ_LEN_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       sp0_wrr1,
  input  logic [num_of_queues-1:0]                   queue_nonempty,
  input  logic [num_of_queues*weight_width-1:0]      weight_in,
  input  logic [num_of_queues*pack_length_width-1:0] pack_length_in,
  input  logic                                       rd_ready,
  input  logic                                       rd_eop,
  output logic                                       grant_vld,
  output logic [queue_sel_width-1:0]                 grant_queue,
  output logic [pack_length_width-1:0]               grant_length,
  output logic                                       busy
`ifdef DEQ_SCHED_STATS_EN
  ,
  output logic [num_of_queues*DEQ_STATS_CNT_WIDTH-1:0] grant_count
`endif
);

  localparam int N  = num_of_queues;
  localparam int SW = queue_sel_width;
  localparam int WW = weight_width;
  localparam int LW = pack_length_width;

  deq_state_e     state_q;
  logic           mode_q;
  logic [SW-1:0]  rr_ptr_q;
  logic [WW-1:0]  credit_q [N];
  logic           grant_vld_q;
  logic [SW-1:0]  grant_queue_q;
  logic [LW-1:0]  grant_length_q;
  logic           busy_q;

  logic [N-1:0]   eligible;
  logic           wrr_found;
  logic [SW-1:0]  wrr_idx;
  logic [SW-1:0]  sp_idx;
  logic [SW-1:0]  pick_idx;
  logic [LW-1:0]  pick_len;
  logic [SW-1:0]  rr_ptr_d;

  always_comb begin
    for (int q = 0; q < N; q++) eligible[q] = queue_nonempty[q] && (credit_q[q] != '0);
  end

  rr_pick #(.N(N), .SW(SW)) u_rr_pick (
    .req_i   (eligible),
    .start_i (rr_ptr_q),
    .found_o (wrr_found),
    .idx_o   (wrr_idx)
  );

  always_comb begin
    sp_idx = '0;
    for (int q = 0; q < N; q++) if (queue_nonempty[q]) sp_idx = SW'(q);
  end

  assign pick_idx = sp0_wrr1 ? wrr_idx : sp_idx;
  assign pick_len = pack_length_in[pick_idx*LW +: LW];
  assign rr_ptr_d = (grant_queue_q == SW'(N - 1)) ? '0 : grant_queue_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= 1'b0;
      rr_ptr_q       <= '0;
      grant_vld_q    <= 1'b0;
      grant_queue_q  <= '0;
      grant_length_q <= '0;
      busy_q         <= 1'b0;
      for (int q = 0; q < N; q++) credit_q[q] <= '0;
    end else begin
      grant_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_ready && (|queue_nonempty)) begin
            mode_q <= sp0_wrr1;
            if (!sp0_wrr1 || wrr_found) begin
              grant_queue_q  <= pick_idx;
              grant_length_q <= pick_len;
              grant_vld_q    <= 1'b1;
              busy_q         <= 1'b1;
              state_q        <= ST_GRANT;
            end else begin
              state_q <= ST_RELOAD;
            end
          end
        end
        ST_RELOAD: begin
          // A zero weight still earns one grant per round so the queue never stalls.
          for (int q = 0; q < N; q++)
            credit_q[q] <= (weight_in[q*WW +: WW] == '0) ? WW'(1) : weight_in[q*WW +: WW];
          state_q <= ST_IDLE;
        end
        ST_GRANT: begin
          if (mode_q) begin
            credit_q[grant_queue_q] <= credit_q[grant_queue_q] - 1'b1;
            rr_ptr_q                <= rr_ptr_d;
          end
          state_q <= ST_XFER;
        end
        ST_XFER: begin
          if (rd_eop) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_vld    = grant_vld_q;
  assign grant_queue  = grant_queue_q;
  assign grant_length = grant_length_q;
  assign busy         = busy_q;

`ifdef DEQ_SCHED_STATS_EN
  logic [DEQ_STATS_CNT_WIDTH-1:0] cnt_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < N; q++) cnt_q[q] <= '0;
    end else if (state_q == ST_GRANT && cnt_q[grant_queue_q] != '1) begin
      cnt_q[grant_queue_q] <= cnt_q[grant_queue_q] + 1'b1;
    end
  end

  always_comb begin
    for (int q = 0; q < N; q++) grant_count[q*DEQ_STATS_CNT_WIDTH +: DEQ_STATS_CNT_WIDTH] = cnt_q[q];
  end
`endif

endmodule

// File: tb/tb_dequeue_scheduler.sv
// Directed self-checking bench for dequeue_scheduler (SP, WRR, zero weight, back-pressure, reset, stats).
module tb_dequeue_scheduler;
  import dequeue_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sp0_wrr1 = 1'b0;
  logic [7:0]  queue_nonempty = '0;
  logic [31:0] weight_in = '0;
  logic [55:0] pack_length_in = '0;
  logic        rd_ready = 1'b0;
  logic        rd_eop = 1'b0;
  logic        grant_vld;
  logic [2:0]  grant_queue;
  logic [6:0]  grant_length;
  logic        busy;
`ifdef DEQ_SCHED_STATS_EN
  logic [127:0] grant_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  dequeue_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .sp0_wrr1       (sp0_wrr1),
    .queue_nonempty (queue_nonempty),
    .weight_in      (weight_in),
    .pack_length_in (pack_length_in),
    .rd_ready       (rd_ready),
    .rd_eop         (rd_eop),
    .grant_vld      (grant_vld),
    .grant_queue    (grant_queue),
    .grant_length   (grant_length),
    .busy           (busy)
`ifdef DEQ_SCHED_STATS_EN
    ,
    .grant_count    (grant_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Head packet of queue q is q*9+5 words long.
  function automatic int exp_len(input int q);
    return q * 9 + 5;
  endfunction

  // Wait for a grant, check latency/queue/length/pulse shape; optionally end the packet with rd_eop.
  task automatic expect_grant(input string tag, input int exp_q, input int exp_lat, input bit finish_pkt);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (grant_vld !== 1'b1 && lat < 20);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " queue"}, grant_queue, exp_q);
    chk({tag, " length"}, grant_length, exp_len(exp_q));
    chk({tag, " busy at grant"}, busy, 1);
    @(negedge clk);
    chk({tag, " vld pulse"}, grant_vld, 0);
    chk({tag, " busy in xfer"}, busy, 1);
    if (finish_pkt) begin
      rd_eop = 1'b1;
      @(negedge clk);
      rd_eop = 1'b0;
      chk({tag, " busy after eop"}, busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int q = 0; q < 8; q++) pack_length_in[q*7 +: 7] = 7'(exp_len(q));

    #1;
    chk("reset vld", grant_vld, 0);
    chk("reset queue", grant_queue, 0);
    chk("reset length", grant_length, 0);
    chk("reset busy", busy, 0);
    do_reset();

    // Strict priority, queues drain one by one.
    rd_ready = 1'b1;
    queue_nonempty = 8'b1000_0101;
    expect_grant("sp q7", 7, 1, 1'b1);
    queue_nonempty = 8'b0000_0101;
    expect_grant("sp q2", 2, 1, 1'b1);
    queue_nonempty = 8'b0000_0001;
    expect_grant("sp q0", 0, 1, 1'b1);

    // Back-pressure from the read controller.
    rd_ready = 1'b0;
    queue_nonempty = 8'h10;
    repeat (5) begin
      @(negedge clk);
      chk("not ready vld", grant_vld, 0);
      chk("not ready busy", busy, 0);
    end
    rd_ready = 1'b1;
    expect_grant("ready q4", 4, 1, 1'b1);
    queue_nonempty = '0;

    // WRR q0=2, q1=1; credits start at zero so the first pick reloads.
    do_reset();
    sp0_wrr1 = 1'b1;
    weight_in = '0;
    weight_in[0 +: 4] = 4'd2;
    weight_in[4 +: 4] = 4'd1;
    queue_nonempty = 8'h03;
    expect_grant("wrr1 q0", 0, 3, 1'b1);
    expect_grant("wrr2 q1", 1, 1, 1'b1);
    expect_grant("wrr3 q0", 0, 1, 1'b1);
    expect_grant("wrr4 q1", 1, 3, 1'b1);
    expect_grant("wrr5 q0", 0, 1, 1'b1);
    expect_grant("wrr6 q0", 0, 1, 1'b1);

    // Zero weight behaves as weight 1: every grant needs a reload.
    do_reset();
    weight_in = '0;
    queue_nonempty = 8'h08;
    expect_grant("w0 a q3", 3, 3, 1'b1);
    expect_grant("w0 b q3", 3, 3, 1'b1);
    expect_grant("w0 c q3", 3, 3, 1'b1);

    // Reset mid-packet clears outputs and credits.
    do_reset();
    weight_in[8 +: 4] = 4'd3;
    queue_nonempty = 8'h04;
    expect_grant("pre-rst q2", 2, 3, 1'b0);
    rst = 1'b1;
    #1;
    chk("xfer rst vld", grant_vld, 0);
    chk("xfer rst queue", grant_queue, 0);
    chk("xfer rst length", grant_length, 0);
    chk("xfer rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_grant("post-rst q2", 2, 3, 1'b1);
    queue_nonempty = '0;
    sp0_wrr1 = 1'b0;

`ifdef DEQ_SCHED_STATS_EN
    do_reset();
    queue_nonempty = 8'h20;
    expect_grant("stats a q5", 5, 1, 1'b1);
    expect_grant("stats b q5", 5, 1, 1'b1);
    expect_grant("stats c q5", 5, 1, 1'b1);
    queue_nonempty = '0;
    for (int q = 0; q < 8; q++) begin
      int expc;
      expc = (q == 5) ? 3 : 0;
      chk($sformatf("grant_count[%0d]", q), {16'd0, grant_count[q*16 +: 16]}, expc);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
